lsu_subword_ctrl: RTL and testbench

- Load/store control stage sitting directly upstream of the word-only data memory in the MEM stage of the pipelined RISC-V core.
- Turns RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses.
- Sub-word stores become read-modify-write sequences; loaded words are sign/zero-extended.
- Stalls the pipeline while busy and flags misaligned or out-of-range accesses.

---
 rtl/lsu_subword_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_lsu_subword_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_subword_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_subword_ctrl
// MEM-stage load/store controller in front of a word-only data memory.
// RV32I byte/half/word loads and stores are mapped onto 32-bit memory words:
// loads are extracted and sign/zero-extended, sub-word stores become a
// read-modify-write, and misaligned or out-of-range requests raise a fault.
//
// Ports
//   clk, resetn         clock (rising edge), asynchronous active-low reset
//   req_valid/we        request present / 1 = store
//   req_funct3          RV32I width code (0 B, 1 H, 2 W, 4 BU, 5 HU)
//   req_addr/wdata      byte address / store data
//   stall               pipeline freeze
//   rdata/rdata_valid   extended load result / one-cycle valid pulse
//   fault               one-cycle pulse for a misaligned or out-of-range access
//   mem_A/WD/WE         word address, write data and write enable to memory
//   mem_RD              memory read data (one cycle after mem_A)
// -----------------------------------------------------------------------------
module lsu_subword_ctrl #(
  parameter int unsigned DMEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        fault,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LD_WAIT   = 2'd1,
    S_RMW_WAIT  = 2'd2,
    S_RMW_WRITE = 2'd3
  } state_e;

  state_e      state_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic [31:0] buf_q;
  logic [31:0] rdata_q;
  logic        rdata_valid_q;
  logic        fault_q;

  logic in_idle_s;
  logic f3_legal_s;
  logic misaligned_s;
  logic oor_s;
  logic fault_s;
  logic go_s;
  logic accept_ld_s;
  logic accept_rmw_s;
  logic accept_sw_s;

  // Select the addressed byte/half of a loaded word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    res = {{24{b[7]}}, b};
      3'd1:    res = {{16{h[15]}}, h};
      3'd4:    res = {24'd0, b};
      3'd5:    res = {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Overlay store data onto the old word at the addressed lane; funct3[0]
  // distinguishes half (1) from byte (0) since only SB/SH reach here.
  function automatic logic [31:0] rmw_merge(input logic [31:0] word,
                                            input logic [15:0] wdata,
                                            input logic [2:0]  f3,
                                            input logic [1:0]  off);
    logic [31:0] res;
    res = word;
    if (f3[0] == 1'b0) begin
      res[{off, 3'b000} +: 8] = wdata[7:0];
    end else if (off[1]) begin
      res[31:16] = wdata;
    end else begin
      res[15:0] = wdata;
    end
    return res;
  endfunction

  // Request decode and memory-side/stall outputs.
  always_comb begin
    in_idle_s    = (state_q == S_IDLE);
    f3_legal_s   = 1'b0;
    misaligned_s = 1'b0;
    case (req_funct3)
      3'd0, 3'd1, 3'd2, 3'd4, 3'd5: f3_legal_s = 1'b1;
      default:                      f3_legal_s = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'b01:   misaligned_s = req_addr[0];
      2'b10:   misaligned_s = (req_addr[1:0] != 2'b00);
      default: misaligned_s = 1'b0;
    endcase
    oor_s        = ({2'b00, req_addr[31:2]} >= 32'(DMEM_WORDS));
    fault_s      = in_idle_s & req_valid & f3_legal_s & (misaligned_s | oor_s);
    go_s         = in_idle_s & req_valid & f3_legal_s & ~(misaligned_s | oor_s);
    accept_ld_s  = go_s & ~req_we;
    accept_rmw_s = go_s & req_we & (req_funct3 == 3'd0 || req_funct3 == 3'd1);
    accept_sw_s  = go_s & req_we & (req_funct3 == 3'd2);

    // Gating with resetn keeps the pipeline and memory quiet during reset.
    stall  = resetn & (~in_idle_s | accept_ld_s | accept_rmw_s);
    mem_WE = resetn & (accept_sw_s | (state_q == S_RMW_WRITE));
    if (in_idle_s) begin
      mem_A  = {req_addr[31:2], 2'b00};
      mem_WD = req_wdata;
    end else begin
      mem_A  = {addr_q[31:2], 2'b00};
      mem_WD = buf_q;
    end
  end

  // Controller FSM, request latch, write buffer and registered result flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      f3_q          <= 3'd0;
      addr_q        <= 32'd0;
      wdata_q       <= 16'd0;
      buf_q         <= 32'd0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      fault_q       <= fault_s;
      case (state_q)
        S_IDLE: begin
          if (accept_ld_s || accept_rmw_s) begin
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata[15:0];
            state_q <= accept_ld_s ? S_LD_WAIT : S_RMW_WAIT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LD_WAIT: begin
          rdata_q       <= load_extend(mem_RD, f3_q, addr_q[1:0]);
          rdata_valid_q <= 1'b1;
          state_q       <= S_IDLE;
        end
        S_RMW_WAIT: begin
          buf_q   <= rmw_merge(mem_RD, wdata_q, f3_q, addr_q[1:0]);
          state_q <= S_RMW_WRITE;
        end
        S_RMW_WRITE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for lsu_subword_ctrl: directed steps followed by random requests,
// checked against a byte-addressed reference memory and a timing model.
// -----------------------------------------------------------------------------
module tb_lsu_subword_ctrl;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        fault;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  int checks;
  int failures;

  logic [31:0] mem [0:4095];
  bit          mem_ready;
  logic [7:0]  ref_b [0:16383];
  logic [31:0] last_rd;

  lsu_subword_ctrl #(.DMEM_WORDS(4096)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .fault       (fault),
    .mem_A       (mem_A),
    .mem_WD      (mem_WD),
    .mem_WE      (mem_WE),
    .mem_RD      (mem_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] seed_word(input int w);
    if (w == 4) return 32'h8899AABB;
    return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Word-only data memory with one-cycle read latency.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) mem[i] <= seed_word(i);
      mem_ready <= 1'b1;
    end else if (mem_WE) begin
      mem[mem_A[13:2]] <= mem_WD;
    end
    mem_RD <= mem[mem_A[13:2]];
  end

  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input int size, input bit sgn);
    logic [31:0] v;
    v = 32'd0;
    for (int k = 0; k < size; k++) v = v | (32'(ref_b[int'(addr[13:0]) + k]) << (8 * k));
    if (sgn && size < 4 && v[8*size-1]) v = v | (32'hFFFFFFFF << (8 * size));
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Present one request for a single cycle and observe a six-cycle window.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd_obs);
    int st_cnt, we_cnt, rv_cnt, f_cnt, we_cyc, rv_cyc, f_cyc, size;
    logic [31:0] we_wd, we_a, exp_wd, exp_rd, rd_final;
    bit legal, mis, oor, flt, is_ld, is_sub, is_sw;
    st_cnt = 0; we_cnt = 0; rv_cnt = 0; f_cnt = 0;
    we_cyc = -1; rv_cyc = -1; f_cyc = -1;
    we_wd = 32'd0; we_a = 32'd0; rd_obs = 32'd0; rd_final = 32'd0;
    legal  = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size   = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    mis    = (size == 2 && (addr % 2) != 0) || (size == 4 && (addr % 4) != 0);
    oor    = (addr >> 2) >= 32'd4096;
    flt    = legal && (mis || oor);
    is_ld  = legal && !flt && !we;
    is_sub = legal && !flt && we && size < 4;
    is_sw  = legal && !flt && we && size == 4;
    exp_rd = is_ld ? ref_load(addr, size, f3 < 3'd4) : 32'd0;
    exp_wd = 32'd0;
    if (is_sub || is_sw) begin
      for (int k = 0; k < size; k++) ref_b[int'(addr[13:0]) + k] = 8'(wd >> (8 * k));
      exp_wd = ref_word(int'(addr[13:2]));
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      end else begin
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
      end
      #1;
      if (stall) st_cnt++;
      if (mem_WE) begin we_cnt++; we_cyc = c; we_wd = mem_WD; we_a = mem_A; end
      if (rdata_valid) begin rv_cnt++; rv_cyc = c; rd_obs = rdata; end
      if (fault) begin f_cnt++; f_cyc = c; end
      rd_final = rdata;
    end
    check("stall_cycles", 32'(st_cnt), is_ld ? 32'd2 : (is_sub ? 32'd3 : 32'd0));
    check("we_pulses", 32'(we_cnt), (is_sub || is_sw) ? 32'd1 : 32'd0);
    if (is_sub || is_sw) begin
      check("we_cycle", 32'(we_cyc), is_sw ? 32'd0 : 32'd2);
      check("mem_WD", we_wd, exp_wd);
      check("mem_A", we_a, {addr[31:2], 2'b00});
    end
    check("rvalid_pulses", 32'(rv_cnt), is_ld ? 32'd1 : 32'd0);
    if (is_ld) begin
      check("rvalid_cycle", 32'(rv_cyc), 32'd2);
      check("rdata", rd_obs, exp_rd);
      last_rd = exp_rd;
    end
    check("fault_pulses", 32'(f_cnt), flt ? 32'd1 : 32'd0);
    if (flt) check("fault_cycle", 32'(f_cyc), 32'd1);
    check("rdata_hold", rd_final, last_rd);
  endtask

  initial begin
    logic [31:0] obs;
    logic        rwe;
    logic [2:0]  rf3;
    logic [31:0] raddr;
    logic [2:0]  ld_codes [8];
    checks = 0; failures = 0; last_rd = 32'd0;
    ld_codes[0] = 3'd0; ld_codes[1] = 3'd1; ld_codes[2] = 3'd2; ld_codes[3] = 3'd4;
    ld_codes[4] = 3'd5; ld_codes[5] = 3'd3; ld_codes[6] = 3'd6; ld_codes[7] = 3'd7;
    for (int w = 0; w < 4096; w++)
      for (int k = 0; k < 4; k++) ref_b[4*w+k] = 8'(seed_word(w) >> (8 * k));

    resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rvalid", {31'd0, rdata_valid}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_we", {31'd0, mem_WE}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed steps from the load/store scenarios.
    run_req(1'b0, 3'd0, 32'h13, 32'd0, obs);  check("lb_0x13", obs, 32'hFFFFFF88);
    run_req(1'b0, 3'd4, 32'h13, 32'd0, obs);  check("lbu_0x13", obs, 32'h00000088);
    run_req(1'b0, 3'd1, 32'h12, 32'd0, obs);  check("lh_0x12", obs, 32'hFFFF8899);
    run_req(1'b0, 3'd5, 32'h10, 32'd0, obs);  check("lhu_0x10", obs, 32'h0000AABB);
    run_req(1'b0, 3'd2, 32'h10, 32'd0, obs);  check("lw_0x10", obs, 32'h8899AABB);
    run_req(1'b1, 3'd0, 32'h11, 32'h000000CC, obs);
    run_req(1'b0, 3'd2, 32'h10, 32'd0, obs);  check("lw_after_sb", obs, 32'h8899CCBB);
    run_req(1'b1, 3'd2, 32'h20, 32'h12345678, obs);
    run_req(1'b0, 3'd2, 32'h20, 32'd0, obs);  check("lw_after_sw", obs, 32'h12345678);
    run_req(1'b0, 3'd1, 32'h11, 32'd0, obs);
    run_req(1'b1, 3'd2, 32'h22, 32'hDEADBEEF, obs);
    run_req(1'b0, 3'd2, 32'h4000, 32'd0, obs);
    run_req(1'b0, 3'd3, 32'h10, 32'd0, obs);
    run_req(1'b0, 3'd2, 32'h3FFC, 32'd0, obs);

    // Reset while an SH is waiting for its read data.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h14; req_wdata = 32'h0000BEEF;
    #1;
    check("sh_accept_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("sh_wait_stall", {31'd0, stall}, 32'd1);
    resetn = 1'b0;
    #1;
    check("midrmw_stall", {31'd0, stall}, 32'd0);
    check("midrmw_we", {31'd0, mem_WE}, 32'd0);
    check("midrmw_rdata", rdata, 32'd0);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("midrmw_we_hold", {31'd0, mem_WE}, 32'd0);
    end
    check("midrmw_word5", mem[5], ref_word(5));
    @(negedge clk);
    resetn = 1'b1;
    last_rd = 32'd0;
    run_req(1'b0, 3'd2, 32'h14, 32'd0, obs);
    check("lw_after_reset", obs, ref_word(5));

    // Random requests, mostly in a small window plus the range boundary.
    for (int n = 0; n < 60; n++) begin
      rwe = 1'($urandom);
      rf3 = rwe ? 3'($urandom_range(0, 3)) : ld_codes[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) raddr = 32'h3FF0 + 32'($urandom_range(0, 31));
      else raddr = 32'($urandom_range(0, 63));
      run_req(rwe, rf3, raddr, $urandom, obs);
    end

    for (int w = 0; w < 16; w++) check("final_mem", mem[w], ref_word(w));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
